// File: rtl/opl_host_bridge.sv
// opl_host_bridge: host bus front end for an OPL-style register core.
// Decodes address/data port strobes, queues register writes towards the core
// with a minimum idle spacing after each issued write, and serves status reads.
// Build option: define OPL_HOST_BRIDGE_FIFO_EN for a FIFO_DEPTH-entry write
// queue; without it a single holding register buffers one pending write.
module opl_host_bridge #(
  parameter int  NUM_BANKS  = 2,
  parameter int  FIFO_DEPTH = 8,
  parameter int  WR_SPACING = 32,
  localparam int AW         = $clog2(NUM_BANKS) + 1,
  localparam int BW         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic          clk,
  input  logic          ic_n,
  input  logic          cs_n,
  input  logic          rd_n,
  input  logic          wr_n,
  input  logic [AW-1:0] address,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  input  logic [7:0]    status_in,
  output logic          reg_wr_valid,
  input  logic          reg_wr_ready,
  output logic [BW-1:0] reg_wr_bank,
  output logic [7:0]    reg_wr_addr,
  output logic [7:0]    reg_wr_data,
  output logic          busy
);

`ifdef OPL_HOST_BRIDGE_FIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`else
  localparam int DEPTH = 1;
  // Queue depth has no meaning with a single holding register.
  localparam int unused_fifo_depth = FIFO_DEPTH;
`endif
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [BW-1:0] bank;
    logic [7:0]    addr;
    logic [7:0]    data;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Reset synchroniser: asserts with ic_n, releases two clk edges later.
  // ---------------------------------------------------------------------------
  logic rst_meta_q, rst_meta_d;
  logic rst_sync_q, rst_sync_d;
  logic rst_n;

  // Synchroniser next state: shift a 1 in behind the released ic_n.
  always_comb begin
    rst_meta_d = 1'b1;
    rst_sync_d = rst_meta_q;
  end

  // Synchroniser flops, cleared asynchronously by ic_n.
  always_ff @(posedge clk or negedge ic_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!ic_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= rst_meta_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n = rst_sync_q;

  // ---------------------------------------------------------------------------
  // Bank field decode; legal bank counts are powers of two so the field width
  // already reduces it modulo NUM_BANKS.
  // ---------------------------------------------------------------------------
  logic [BW-1:0] bank_in;

  generate
    if (NUM_BANKS > 1) begin : g_bank
      assign bank_in = address[AW-1:1];
    end else begin : g_no_bank
      assign bank_in = '0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic          wr_hist_q, wr_hist_d;
  logic          rd_hist_q, rd_hist_d;
  logic [7:0]    addr_q, addr_d;
  logic [BW-1:0] bank_q, bank_d;
  logic [7:0]    dout_q, dout_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    spacing_q, spacing_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  entry_t        head_q, head_d;
`ifdef OPL_HOST_BRIDGE_FIFO_EN
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  entry_t        mem_q [DEPTH];
`endif

  // Strobe events fire on the first low sample after a high sample.
  logic          wr_evt, rd_evt;
  logic          push_req, push_acc, pop, full, ovf_set, ovf_clr;
  logic [CW-1:0] remaining;
  entry_t        push_entry;
  logic          unused_status;

  assign wr_evt     = ~(cs_n | wr_n) & wr_hist_q;
  assign rd_evt     = ~(cs_n | rd_n) & rd_hist_q;
  assign push_req   = wr_evt & address[0];
  assign pop        = valid_q & reg_wr_ready;
  assign full       = (count_q == CW'(DEPTH));
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_acc   = push_req & (~full | pop);
  assign ovf_set    = push_req & full & ~pop;
  assign ovf_clr    = rd_evt & ~address[0];
  assign remaining  = count_q - CW'(pop);
  assign push_entry = {bank_q, addr_q, din};
  assign busy       = (count_q != '0) || (spacing_q != '0);
  assign unused_status = ^status_in[4:0];

  // Next-state logic for strobe decode, queue bookkeeping, spacing and status.
  always_comb begin
    // NOTE: every _d is defaulted first so no branch can leave a latch behind.
    wr_hist_d = cs_n | wr_n;
    rd_hist_d = cs_n | rd_n;
    addr_d    = addr_q;
    bank_d    = bank_q;
    dout_d    = dout_q;
    head_d    = head_q;
    count_d   = remaining + CW'(push_acc);
`ifdef OPL_HOST_BRIDGE_FIFO_EN
    // Power-of-two depth: pointer increment wraps naturally.
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d  = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
`endif

    // Address-port write latches the target register and bank.
    if (wr_evt && !address[0]) begin
      addr_d = din;
      bank_d = bank_in;
    end

    // Reads: status port reports flags, data port reads as all ones.
    if (rd_evt) begin
      dout_d = address[0] ? 8'hFF : {status_in[7:5], ovf_q, 3'b000, busy};
    end

    // A new overflow in the same cycle as the clearing read survives.
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;

    // Spacing counter reloads on every transfer and counts down to zero.
    if (pop) begin
      spacing_d = 8'(WR_SPACING);
    end else if (spacing_q != '0) begin
      spacing_d = spacing_q - 8'd1;
    end else begin
      spacing_d = spacing_q;
    end

    // Head register drives the payload; it only changes when the head entry does.
    if (push_acc && (remaining == '0)) begin
      head_d = push_entry;
    end
`ifdef OPL_HOST_BRIDGE_FIFO_EN
    else if (pop && (remaining != '0)) begin
      head_d = mem_q[rd_ptr_d];
    end
`endif

    valid_d = (count_d != '0) && (spacing_d == '0);
  end

  // Main state register, held in reset until the synchronised release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_hist_q <= 1'b1;
      rd_hist_q <= 1'b1;
      addr_q    <= '0;
      bank_q    <= '0;
      dout_q    <= '0;
      ovf_q     <= 1'b0;
      spacing_q <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      head_q    <= '0;
`ifdef OPL_HOST_BRIDGE_FIFO_EN
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
`endif
    end else begin
      wr_hist_q <= wr_hist_d;
      rd_hist_q <= rd_hist_d;
      addr_q    <= addr_d;
      bank_q    <= bank_d;
      dout_q    <= dout_d;
      ovf_q     <= ovf_d;
      spacing_q <= spacing_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      head_q    <= head_d;
`ifdef OPL_HOST_BRIDGE_FIFO_EN
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
`endif
    end
  end

`ifdef OPL_HOST_BRIDGE_FIFO_EN
  // Queue storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count_q and the pointers decide which entries are live.
    if (push_acc) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end
`endif

  assign dout         = dout_q;
  assign reg_wr_valid = valid_q;
  assign reg_wr_bank  = head_q.bank;
  assign reg_wr_addr  = head_q.addr;
  assign reg_wr_data  = head_q.data;

endmodule
